boot_loader_ctrl: RTL and testbench
===================================

BOOT_LOADER_CTRL -- requirements
Module: boot_loader_ctrl

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 16: width of RAM address and load counter.
REQ-002 SHALL have parameter RELEASE_CYCLES, default 2: cycles CPU_RESET is held after the final write.
REQ-003 CLK  input  1  single clock; all logic on rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 START  input  1  one-cycle request to begin a program load.
REQ-006 LD_BASE  input  ADDRESS_WIDTH  first RAM address, sampled on START.
REQ-007 LD_VALID / LD_READY / LD_LAST  input / output / input  1 each  load-word stream handshake; LD_LAST marks the final word.
REQ-008 LD_DATA  input  16  program word.
REQ-009 CPU_RAM_EN, CPU_RAM_RW  input  1 each  CPU-side RAM strobes (RW: 1 = read, 0 = write).
REQ-010 CPU_ADDRESS  input  ADDRESS_WIDTH; CPU_WDATA  input  16  CPU-side RAM address/data.
REQ-011 RAM_EN, RAM_RW  output  1 each; RAM_ADDRESS  output  ADDRESS_WIDTH; RAM_WDATA  output  16  muxed RAM port.
REQ-012 HALT, CPU_RESET  output  1 each  CPU hold controls.
REQ-013 DONE  output  1  high in RUN; WORD_COUNT  output  ADDRESS_WIDTH  words written; WRAP  output  1  sticky address wrap-around flag.

Function
REQ-014 FSM states SHALL be IDLE, LOAD, DRAIN, RELEASE, RUN.
REQ-015 IDLE: HALT=1, CPU_RESET=1, LD_READY=0, RAM_EN=0; START -> LOAD, address counter <= LD_BASE, WORD_COUNT <= 0, WRAP <= 0.
REQ-016 LOAD: LD_READY=1; each cycle with LD_VALID&&LD_READY SHALL produce a registered write one cycle later: RAM_EN=1, RAM_RW=0, RAM_ADDRESS=counter, RAM_WDATA=LD_DATA.
REQ-017 After each accepted word the address counter SHALL increment by 1 and WORD_COUNT SHALL increment by 1.
REQ-018 Cycles without a handshake in LOAD SHALL drive RAM_EN=0 (no write bubble-fill).
REQ-019 Counter increment from all-ones SHALL wrap to 0 and set WRAP; loading SHALL continue.
REQ-020 Handshake with LD_LAST=1 -> DRAIN; LD_READY SHALL be 0 in DRAIN, RELEASE and RUN.
REQ-021 DRAIN lasts exactly 1 cycle (final write visible on RAM port), then -> RELEASE.
REQ-022 RELEASE: RAM_EN=0, HALT=1, CPU_RESET=1 for RELEASE_CYCLES cycles, then -> RUN.
REQ-023 RUN: HALT=0, CPU_RESET=0, DONE=1; RAM port SHALL combinationally follow the CPU_* inputs.
REQ-024 START in LOAD, DRAIN, RELEASE or RUN SHALL be ignored.
REQ-025 CPU_* inputs SHALL have no effect on the RAM port outside RUN.

Reset
REQ-026 RESET SHALL take priority over all inputs and force IDLE on the next edge from any state, including mid-LOAD (any pending write dropped).
REQ-027 Reset values: HALT=1, CPU_RESET=1, LD_READY=0, RAM_EN=0, RAM_RW=1, RAM_ADDRESS=0, RAM_WDATA=0, DONE=0, WORD_COUNT=0, WRAP=0.

Configuration
REQ-028 With BOOT_LOADER_CHECKSUM_EN defined: output CHECKSUM (16) SHALL hold the modulo-2^16 sum of all accepted LD_DATA words, cleared on START and RESET.
REQ-029 Without BOOT_LOADER_CHECKSUM_EN: no CHECKSUM port and no summing logic.

Structure
REQ-030 FSM state encoding and the RAM_RW read/write constants SHALL live in shared package bat_amateur_pkg.
REQ-031 The RAM port mux SHALL be a sub-module named ram_port_mux; the rest stays in boot_loader_ctrl.

Verification
REQ-032 Reset then START, LD_BASE=0x0010, words 0x0000,0x0001,0x0005 (last) -> writes at 0x10/0x11/0x12, WORD_COUNT=3, DONE after DRAIN+2 cycles.
REQ-033 LD_VALID toggled every other cycle while loading 4 words -> exactly 4 RAM_EN write pulses, consecutive addresses, no extra writes.
REQ-034 LD_BASE=0xFFFE, 3 words -> addresses 0xFFFE, 0xFFFF, 0x0000; WRAP=1.
REQ-035 RESET asserted after 2 of 5 words -> IDLE next edge, HALT=1, RAM_EN=0, WORD_COUNT=0; subsequent START reloads normally.
REQ-036 In RUN, CPU read at 0x0004 -> RAM_EN=1, RAM_RW=1, RAM_ADDRESS=0x0004 same cycle; START pulse in RUN -> no state change.
REQ-037 With BOOT_LOADER_CHECKSUM_EN, words 0xFFFF and 0x0002 -> CHECKSUM=0x0001.

Source files
------------

// File: rtl/bat_amateur_pkg.sv
// Shared definitions for the boot loader: FSM state encoding and RAM read/write strobe values.
package bat_amateur_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_RELEASE = 3'd3,
    ST_RUN     = 3'd4
  } boot_state_e;

  // RAM_RW polarity: high reads, low writes.
  localparam logic RAM_RW_READ  = 1'b1;
  localparam logic RAM_RW_WRITE = 1'b0;

  localparam int WORD_WIDTH = 16;

  // The CPU owns the RAM port only once the loader has released it.
  function automatic logic cpu_owns_ram(input boot_state_e s);
    return (s == ST_RUN);
  endfunction

endpackage

// File: rtl/boot_loader_ctrl_ram_port_mux.sv
// RAM port selector: the registered loader write path while loading, the CPU strobes
// (purely combinational) once the program is running.
module ram_port_mux #(
  parameter int ADDRESS_WIDTH = 16
) (
  input  logic                     sel_cpu,
  input  logic                     ld_en,
  input  logic                     ld_rw,
  input  logic [ADDRESS_WIDTH-1:0] ld_address,
  input  logic [15:0]              ld_wdata,
  input  logic                     cpu_en,
  input  logic                     cpu_rw,
  input  logic [ADDRESS_WIDTH-1:0] cpu_address,
  input  logic [15:0]              cpu_wdata,
  output logic                     ram_en,
  output logic                     ram_rw,
  output logic [ADDRESS_WIDTH-1:0] ram_address,
  output logic [15:0]              ram_wdata
);

  always_comb begin
    ram_en      = ld_en;
    ram_rw      = ld_rw;
    ram_address = ld_address;
    ram_wdata   = ld_wdata;
    if (sel_cpu) begin
      ram_en      = cpu_en;
      ram_rw      = cpu_rw;
      ram_address = cpu_address;
      ram_wdata   = cpu_wdata;
    end
  end

endmodule

// File: rtl/boot_loader_ctrl.sv
// Boot loader: streams program words into RAM while holding the CPU in reset, then hands
// the RAM port to the CPU. Optional running checksum enabled by BOOT_LOADER_CHECKSUM_EN.
module boot_loader_ctrl
  import bat_amateur_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 16,
  parameter int RELEASE_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] ld_base,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic                     ld_last,
  input  logic [15:0]              ld_data,
  input  logic                     cpu_ram_en,
  input  logic                     cpu_ram_rw,
  input  logic [ADDRESS_WIDTH-1:0] cpu_address,
  input  logic [15:0]              cpu_wdata,
  output logic                     ram_en,
  output logic                     ram_rw,
  output logic [ADDRESS_WIDTH-1:0] ram_address,
  output logic [15:0]              ram_wdata,
  output logic                     halt,
  output logic                     cpu_reset,
  output logic                     done,
  output logic [ADDRESS_WIDTH-1:0] word_count,
`ifdef BOOT_LOADER_CHECKSUM_EN
  output logic [15:0]              checksum,
`endif
  output logic                     wrap
);

  // RELEASE_CYCLES is expected to be at least 1.
  localparam logic [15:0] REL_LAST = 16'(RELEASE_CYCLES - 1);

  boot_state_e state_reg, state_next;

  logic [ADDRESS_WIDTH-1:0] addr_reg;
  logic [ADDRESS_WIDTH-1:0] word_count_reg;
  logic                     wrap_reg;
  logic [15:0]              rel_cnt_reg;

  logic                     wr_en_reg;
  logic                     wr_rw_reg;
  logic [ADDRESS_WIDTH-1:0] wr_addr_reg;
  logic [15:0]              wr_data_reg;

  logic accept;
  logic load_begin;

  assign accept     = ld_valid && ld_ready;
  assign load_begin = (state_reg == ST_IDLE) && start;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    halt       = 1'b1;
    cpu_reset  = 1'b1;
    ld_ready   = 1'b0;
    done       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid && ld_last) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        state_next = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (rel_cnt_reg == REL_LAST) state_next = ST_RUN;
      end
      ST_RUN: begin
        halt      = 1'b0;
        cpu_reset = 1'b0;
        done      = 1'b1;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || state_reg != ST_RELEASE) begin
      rel_cnt_reg <= '0;
    end else begin
      rel_cnt_reg <= rel_cnt_reg + 16'd1;
    end
  end

  // Each accepted word becomes a one-cycle write on the following cycle; idle cycles
  // drop RAM_EN rather than repeating the last word.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_reg       <= '0;
      word_count_reg <= '0;
      wrap_reg       <= 1'b0;
      wr_en_reg      <= 1'b0;
      wr_rw_reg      <= RAM_RW_READ;
      wr_addr_reg    <= '0;
      wr_data_reg    <= '0;
    end else begin
      wr_en_reg <= accept;
      wr_rw_reg <= accept ? RAM_RW_WRITE : RAM_RW_READ;
      if (accept) begin
        wr_addr_reg    <= addr_reg;
        wr_data_reg    <= ld_data;
        addr_reg       <= addr_reg + 1'b1;
        word_count_reg <= word_count_reg + 1'b1;
        if (&addr_reg) wrap_reg <= 1'b1;
      end
      if (load_begin) begin
        addr_reg       <= ld_base;
        word_count_reg <= '0;
        wrap_reg       <= 1'b0;
      end
    end
  end

`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [15:0] checksum_reg;

  always_ff @(posedge clk) begin
    if (reset || load_begin) begin
      checksum_reg <= '0;
    end else if (accept) begin
      checksum_reg <= checksum_reg + ld_data;
    end
  end

  assign checksum = checksum_reg;
`endif

  assign word_count = word_count_reg;
  assign wrap       = wrap_reg;

  ram_port_mux #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) u_ram_port_mux (
    .sel_cpu     (cpu_owns_ram(state_reg)),
    .ld_en       (wr_en_reg),
    .ld_rw       (wr_rw_reg),
    .ld_address  (wr_addr_reg),
    .ld_wdata    (wr_data_reg),
    .cpu_en      (cpu_ram_en),
    .cpu_rw      (cpu_ram_rw),
    .cpu_address (cpu_address),
    .cpu_wdata   (cpu_wdata),
    .ram_en      (ram_en),
    .ram_rw      (ram_rw),
    .ram_address (ram_address),
    .ram_wdata   (ram_wdata)
  );

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Directed bench for boot_loader_ctrl: loader writes are predicted into a scoreboard queue
// when each handshake is driven and popped by a monitor as they appear on the RAM port.
module tb_boot_loader_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] ld_base;
  logic        ld_valid;
  logic        ld_ready;
  logic        ld_last;
  logic [15:0] ld_data;
  logic        cpu_ram_en;
  logic        cpu_ram_rw;
  logic [15:0] cpu_address;
  logic [15:0] cpu_wdata;
  logic        ram_en;
  logic        ram_rw;
  logic [15:0] ram_address;
  logic [15:0] ram_wdata;
  logic        halt;
  logic        cpu_reset;
  logic        done;
  logic [15:0] word_count;
  logic        wrap;
`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  int checks = 0;
  int errors = 0;
  int writes_seen = 0;

  logic [31:0] exp_q[$];
  logic [15:0] exp_addr;
  logic [15:0] exp_cnt;
  logic [15:0] exp_sum;

  boot_loader_ctrl #(
    .ADDRESS_WIDTH(16),
    .RELEASE_CYCLES(2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ld_base     (ld_base),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_last     (ld_last),
    .ld_data     (ld_data),
    .cpu_ram_en  (cpu_ram_en),
    .cpu_ram_rw  (cpu_ram_rw),
    .cpu_address (cpu_address),
    .cpu_wdata   (cpu_wdata),
    .ram_en      (ram_en),
    .ram_rw      (ram_rw),
    .ram_address (ram_address),
    .ram_wdata   (ram_wdata),
    .halt        (halt),
    .cpu_reset   (cpu_reset),
    .done        (done),
    .word_count  (word_count),
`ifdef BOOT_LOADER_CHECKSUM_EN
    .checksum    (checksum),
`endif
    .wrap        (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Loader writes outside RUN are matched in order against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (ram_en === 1'b1 && ram_rw === 1'b0 && done !== 1'b1) begin
        writes_seen++;
        chk("write_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          logic [31:0] e;
          e = exp_q.pop_front();
          chk("write_addr_data", {ram_address, ram_wdata}, e);
          $display("write addr=%h data=%h", ram_address, ram_wdata);
        end
      end
    end
  end

  task automatic apply_reset();
    reset    = 1'b1;
    start    = 1'b0;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic do_start(input logic [15:0] base);
    start   = 1'b1;
    ld_base = base;
    @(negedge clk);
    start    = 1'b0;
    exp_addr = base;
    exp_cnt  = '0;
    exp_sum  = '0;
  endtask

  task automatic load_word(input logic [15:0] d, input logic last, input logic valid);
    ld_valid = valid;
    ld_data  = d;
    ld_last  = last;
    #1;
    if (ld_valid && ld_ready === 1'b1) begin
      exp_q.push_back({exp_addr, d});
      exp_addr = exp_addr + 16'd1;
      exp_cnt  = exp_cnt + 16'd1;
      exp_sum  = exp_sum + d;
    end
    @(negedge clk);
  endtask

  task automatic wait_done(output int n);
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int w0;
    start       = 1'b0;
    ld_base     = '0;
    ld_valid    = 1'b0;
    ld_last     = 1'b0;
    ld_data     = '0;
    // CPU strobes parked on a conspicuous write; they must not leak outside RUN.
    cpu_ram_en  = 1'b1;
    cpu_ram_rw  = 1'b0;
    cpu_address = 16'h5555;
    cpu_wdata   = 16'hAAAA;
    exp_addr    = '0;
    exp_cnt     = '0;
    exp_sum     = '0;
    apply_reset();
    #1;
    chk("rst_halt", 32'(halt), 32'd1);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_ld_ready", 32'(ld_ready), 32'd0);
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_ram_rw", 32'(ram_rw), 32'd1);
    chk("rst_ram_address", 32'(ram_address), 32'd0);
    chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_word_count", 32'(word_count), 32'd0);
    chk("rst_wrap", 32'(wrap), 32'd0);
    @(negedge clk);

    // Basic three-word load at 0x0010.
    do_start(16'h0010);
    chk("load_ld_ready", 32'(ld_ready), 32'd1);
    load_word(16'h0000, 1'b0, 1'b1);
    load_word(16'h0001, 1'b0, 1'b1);
    load_word(16'h0005, 1'b1, 1'b1);
    chk("drain_ld_ready", 32'(ld_ready), 32'd0);
    chk("drain_halt", 32'(halt), 32'd1);
    wait_done(n);
    chk("a_done_latency", 32'(n), 32'd3);
    chk("a_word_count", 32'(word_count), 32'(exp_cnt));
    chk("a_halt_run", 32'(halt), 32'd0);
    chk("a_cpu_reset_run", 32'(cpu_reset), 32'd0);
    chk("a_scoreboard_empty", 32'(exp_q.size()), 32'd0);
`ifdef BOOT_LOADER_CHECKSUM_EN
    chk("a_checksum", 32'(checksum), 32'(exp_sum));
`endif

    // RUN: CPU owns the port combinationally; START is ignored.
    cpu_ram_en  = 1'b1;
    cpu_ram_rw  = 1'b1;
    cpu_address = 16'h0004;
    #1;
    chk("run_rd_en", 32'(ram_en), 32'd1);
    chk("run_rd_rw", 32'(ram_rw), 32'd1);
    chk("run_rd_addr", 32'(ram_address), 32'h0004);
    cpu_ram_rw  = 1'b0;
    cpu_address = 16'h0123;
    cpu_wdata   = 16'hBEEF;
    #1;
    chk("run_wr_pass", {ram_rw, 15'd0, ram_address}, {1'b0, 15'd0, 16'h0123});
    chk("run_wr_data", 32'(ram_wdata), 32'h0000BEEF);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("run_start_done", 32'(done), 32'd1);
    chk("run_start_ld_ready", 32'(ld_ready), 32'd0);
    chk("run_start_word_count", 32'(word_count), 32'd3);
    cpu_ram_rw  = 1'b0;
    cpu_address = 16'h5555;
    cpu_wdata   = 16'hAAAA;

    // LD_VALID toggling: four accepted words, no bubble writes.
    apply_reset();
    @(negedge clk);
    w0 = writes_seen;
    do_start(16'h0100);
    for (int i = 0; i < 8; i++) begin
      load_word(16'h1000 + 16'(i), (i == 7), i[0]);
    end
    wait_done(n);
    chk("b_done_latency", 32'(n), 32'd3);
    chk("b_write_pulses", 32'(writes_seen - w0), 32'd4);
    chk("b_word_count", 32'(word_count), 32'd4);
    chk("b_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    // Address wrap from 0xFFFF to 0x0000.
    apply_reset();
    do_start(16'hFFFE);
    load_word(16'h0A0A, 1'b0, 1'b1);
    chk("c_wrap_before", 32'(wrap), 32'd0);
    load_word(16'h0B0B, 1'b0, 1'b1);
    chk("c_wrap_after", 32'(wrap), 32'd1);
    load_word(16'h0C0C, 1'b1, 1'b1);
    wait_done(n);
    chk("c_word_count", 32'(word_count), 32'd3);
    chk("c_wrap_final", 32'(wrap), 32'd1);
    chk("c_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a five-word load; the concurrent word is dropped.
    apply_reset();
    do_start(16'h0020);
    load_word(16'h2000, 1'b0, 1'b1);
    load_word(16'h2001, 1'b0, 1'b1);
    reset    = 1'b1;
    ld_valid = 1'b1;
    ld_data  = 16'h2002;
    @(negedge clk);
    chk("d_halt", 32'(halt), 32'd1);
    chk("d_ram_en", 32'(ram_en), 32'd0);
    chk("d_word_count", 32'(word_count), 32'd0);
    chk("d_ld_ready", 32'(ld_ready), 32'd0);
    reset    = 1'b0;
    ld_valid = 1'b0;
    @(negedge clk);
    chk("d_idle_ram_en", 32'(ram_en), 32'd0);
    do_start(16'h0030);
    load_word(16'hFFFF, 1'b0, 1'b1);
    load_word(16'h0002, 1'b1, 1'b1);
    wait_done(n);
    chk("d_done_latency", 32'(n), 32'd3);
    chk("d_word_count_reload", 32'(word_count), 32'd2);
    chk("d_scoreboard_empty", 32'(exp_q.size()), 32'd0);
`ifdef BOOT_LOADER_CHECKSUM_EN
    chk("d_checksum", 32'(checksum), 32'h0001);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
